// File: rtl/quad_step_decoder.sv
// Quadrature (A/B) decoder: synchronizes both phases, emits a one-cycle step pulse with
// direction for every legal Gray-code transition and keeps a wrapping N-bit position count.
module quad_step_decoder #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         clr,
    output logic [N-1:0] q_out,
    output logic         step,
    output logic         dir,
    output logic         err
);

    localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {StInit, StRun} state_e;

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [1:0]             s;

    state_e          state_q, state_d;
    logic [CntW-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]      prev_q, prev_d;
    logic [N-1:0]    q_q, q_d;
    logic            step_q, step_d;
    logic            dir_q, dir_d;
    logic            err_q, err_d;

    logic [1:0] delta;
    logic       is_up;
    logic       is_down;
    logic       is_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
        end
    end

    assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    // Gray code {a,b} to cyclic position: 00=0, 10=1, 11=2, 01=3; up = +1 mod 4.
    function automatic logic [1:0] gray_to_pos(input logic [1:0] g);
        case (g)
            2'b00:   gray_to_pos = 2'd0;
            2'b10:   gray_to_pos = 2'd1;
            2'b11:   gray_to_pos = 2'd2;
            default: gray_to_pos = 2'd3;
        endcase
    endfunction

    always_comb begin
        delta      = gray_to_pos(s) - gray_to_pos(prev_q);
        is_up      = (delta == 2'd1);
        is_down    = (delta == 2'd3);
        is_illegal = (delta == 2'd2);
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = s;
        q_d        = q_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;

        unique case (state_q)
            StInit: begin
                if (init_cnt_q == CntW'(SYNC_STAGES)) begin
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (is_up || is_down) begin
                    step_d = 1'b1;
                    dir_d  = is_up;
                    q_d    = is_up ? q_q + N'(1) : q_q - N'(1);
                end
                if (is_illegal) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase

        // clr beats the count, but an illegal transition in the same cycle re-arms err.
        if (clr) begin
            q_d   = '0;
            err_d = (state_q == StRun) && is_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            prev_q     <= 2'b00;
            q_q        <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            q_q        <= q_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign q_out = q_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios followed by a random phase walk, all
// compared every cycle against a delay-line / position-arithmetic reference model.
module tb_quad_step_decoder;

    localparam int unsigned N  = 4;
    localparam int unsigned SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         a;
    logic         b;
    logic         clr;
    logic [N-1:0] q;
    logic         step;
    logic         dir;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [1:0] hist[$];
    int         init_edges;
    int         m_q;
    bit         m_step;
    bit         m_dir;
    bit         m_err;

    always #5 clk = ~clk;

    quad_step_decoder #(
        .N           (N),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .a_in  (a),
        .b_in  (b),
        .clr   (clr),
        .q_out (q),
        .step  (step),
        .dir   (dir),
        .err   (err)
    );

    function automatic int pos_of(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SS + 1; i++) hist.push_back(2'b00);
        init_edges = 0;
        m_q        = 0;
        m_step     = 0;
        m_dir      = 0;
        m_err      = 0;
    endtask

    // Synchronized value is the input seen SS edges ago; decode compares it to one edge earlier.
    task automatic model_edge();
        logic [1:0] old_s;
        logic [1:0] cur_s;
        int         d;
        bit         illegal;
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back({a, b});
            old_s = hist[0];
            cur_s = hist[1];
            void'(hist.pop_front());
            m_step  = 0;
            illegal = 0;
            if (init_edges < SS + 1) begin
                init_edges++;
            end else begin
                d       = (pos_of(cur_s) - pos_of(old_s) + 4) % 4;
                illegal = (d == 2);
                if (d == 1 || d == 3) begin
                    m_step = 1;
                    m_dir  = (d == 1);
                    m_q    = (m_q + ((d == 1) ? 1 : -1) + (1 << N)) % (1 << N);
                end
            end
            if (clr) begin
                m_q   = 0;
                m_err = illegal;
            end else begin
                m_err = m_err | illegal;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("q_out", 32'(q), 32'(m_q));
        chk("step", 32'(step), 32'(m_step));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_pos(input int p);
        {a, b} = gray_of(p);
    endtask

    initial begin
        int p;
        int nsteps;
        int r;

        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        clr = 1'b0;
        model_reset();
        ticks(2);
        chk("reset_q", 32'(q), 32'd0);

        // Release with both phases high: INIT must swallow the 00 -> 11 jump.
        #3 rst = 1'b0;
        p = 2;
        nsteps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step || err || q != 0) nsteps++;
        end
        chk("t1_quiet", 32'(nsteps), 32'd0);

        p = 3; set_pos(p); ticks(4);
        p = 0; set_pos(p); ticks(4);
        clr = 1'b1; tick(); clr = 1'b0;
        ticks(2);

        nsteps = 0;
        for (int k = 0; k < 4; k++) begin
            p = (p + 1) % 4;
            set_pos(p);
            for (int i = 0; i < 8; i++) begin
                tick();
                if (step) nsteps++;
            end
        end
        chk("t2_steps", 32'(nsteps), 32'd4);
        chk("t2_q", 32'(q), 32'd4);
        chk("t2_dir", 32'(dir), 32'd1);

        clr = 1'b1; tick(); clr = 1'b0;
        ticks(2);
        p = 3; set_pos(p); ticks(6);
        chk("t3_down_q", 32'(q), 32'hF);
        chk("t3_down_dir", 32'(dir), 32'd0);
        for (int k = 0; k < 16; k++) begin
            p = (p + 1) % 4;
            set_pos(p);
            ticks(2);
        end
        ticks(4);
        chk("t3_up_q", 32'(q), 32'hF);
        chk("t3_up_dir", 32'(dir), 32'd1);

        p = 1; set_pos(p); ticks(6);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_q", 32'(q), 32'hF);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4_clr_err", 32'(err), 32'd0);
        chk("t4_clr_q", 32'(q), 32'd0);
        ticks(2);

        p = 2; set_pos(p);
        ticks(SS);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t5_step", 32'(step), 32'd1);
        chk("t5_q", 32'(q), 32'd0);
        chk("t5_dir", 32'(dir), 32'd1);
        ticks(2);

        for (int k = 0; k < 7; k++) begin
            p = (p + 1) % 4;
            set_pos(p);
            ticks(3);
        end
        ticks(3);
        chk("t6_pre_q", 32'(q), 32'd7);

        // Asynchronous reset mid-cycle: outputs must clear before the next edge.
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_async_q", 32'(q), 32'd0);
        chk("t6_async_step", 32'(step), 32'd0);
        chk("t6_async_err", 32'(err), 32'd0);
        ticks(3);
        #3 rst = 1'b0;
        ticks(10);

        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 31));
            if (r < 12) p = (p + 1) % 4;
            else if (r < 22) p = (p + 3) % 4;
            else if (r == 31) p = (p + 2) % 4;
            set_pos(p);
            clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr = 1'b0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
